bcd_scan_display: RTL

- Parametrised multi-digit successor to the single-digit BCD-to-7-segment decoder.
- Latches NUM_DIGITS packed BCD digits on a load strobe, then time-multiplexes them onto one shared segment bus with one-hot digit enables.
- Adds leading-zero blanking, per-digit decimal points, invalid-code flagging and selectable output polarity.
- Sits between counter/datapath logic and the board's common-anode or common-cathode display.

---
 rtl/bcd_scan_display_if.sv | 24 ++
 rtl/bcd_scan_display.sv | 116 +++++++++++
 2 files changed

// File: rtl/bcd_scan_display_if.sv
// Bus between the datapath that owns the BCD value and the multiplexed
// 7-segment display driver.
interface bcd_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] NUM;
    logic [NUM_DIGITS-1:0]   DP;
    logic                    LOAD;
    logic                    BLANK_LZ;
    logic [6:0]              SEG;
    logic                    DP_OUT;
    logic [NUM_DIGITS-1:0]   AN;
    logic                    ERR;

    modport master (
        output NUM, DP, LOAD, BLANK_LZ,
        input  SEG, DP_OUT, AN, ERR
    );

    modport slave (
        input  NUM, DP, LOAD, BLANK_LZ,
        output SEG, DP_OUT, AN, ERR
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Multi-digit BCD display scanner: shadows a packed BCD value and time-multiplexes
// it onto one segment bus with one-hot digit enables, blanking and error flag.
module bcd_scan_display #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input logic              CLK,
    input logic              RST,
    bcd_scan_display_if.slave bus
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0]         PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_MASK   = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_MASK    = {NUM_DIGITS{AN_ACTIVE_LOW}};

    function automatic logic [6:0] decode_bcd(input logic [3:0] code);
        case (code)
            4'd0:    decode_bcd = 7'b1111110;
            4'd1:    decode_bcd = 7'b0110000;
            4'd2:    decode_bcd = 7'b1101101;
            4'd3:    decode_bcd = 7'b1111001;
            4'd4:    decode_bcd = 7'b0110011;
            4'd5:    decode_bcd = 7'b1011011;
            4'd6:    decode_bcd = 7'b1011111;
            4'd7:    decode_bcd = 7'b1110000;
            4'd8:    decode_bcd = 7'b1111111;
            4'd9:    decode_bcd = 7'b1111011;
            default: decode_bcd = 7'b0000001;
        endcase
    endfunction

    function automatic logic [NUM_DIGITS-1:0] one_hot(input logic [IW-1:0] i);
        one_hot = NUM_DIGITS'(1) << i;
    endfunction

    logic [4*NUM_DIGITS-1:0] num_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic                    blz_sh;
    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;

    logic [3:0]              dig [NUM_DIGITS];
    logic [NUM_DIGITS:0]     zero_hi;
    logic                    any_bad;
    logic                    blank_cur;
    logic [6:0]              seg_cur;

    logic [6:0]              seg_p1;
    logic                    dp_p1;
    logic [NUM_DIGITS-1:0]   an_p1;
    logic                    err_p1;

    // zero_hi[k]: digits k..NUM_DIGITS-1 are all zero; invalid codes count as non-zero
    always_comb begin
        zero_hi             = '0;
        zero_hi[NUM_DIGITS] = 1'b1;
        any_bad             = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            dig[k]     = num_sh[4*k +: 4];
            zero_hi[k] = zero_hi[k+1] && (dig[k] == 4'd0);
            any_bad    = any_bad | (dig[k] > 4'd9);
        end
    end

    always_comb begin
        blank_cur = blz_sh && (idx != '0) && zero_hi[idx];
        seg_cur   = blank_cur ? 7'b0000000 : decode_bcd(dig[idx]);
    end

    // Stage p0: shadow capture and scan position
    always_ff @(posedge CLK) begin
        if (RST) begin
            num_sh <= '0;
            dp_sh  <= '0;
            blz_sh <= 1'b0;
            presc  <= '0;
            idx    <= '0;
        end else begin
            if (bus.LOAD) begin
                num_sh <= bus.NUM;
                dp_sh  <= bus.DP;
                blz_sh <= bus.BLANK_LZ;
            end
            if (presc == PRESC_LAST) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Stage p1: output registers, polarity folded in as an XOR mask
    always_ff @(posedge CLK) begin
        if (RST) begin
            seg_p1 <= SEG_MASK;
            dp_p1  <= SEG_ACTIVE_LOW;
            an_p1  <= AN_MASK;
            err_p1 <= 1'b0;
        end else begin
            seg_p1 <= seg_cur ^ SEG_MASK;
            dp_p1  <= dp_sh[idx] ^ SEG_ACTIVE_LOW;
            an_p1  <= one_hot(idx) ^ AN_MASK;
            err_p1 <= any_bad;
        end
    end

    assign bus.SEG    = seg_p1;
    assign bus.DP_OUT = dp_p1;
    assign bus.AN     = an_p1;
    assign bus.ERR    = err_p1;
endmodule
